// File: rtl/counter_rollunder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : counter_rollunder                                          |
// | Description : W-bit loadable down-counter built from N cascaded segments |
// |               of W/N bits, with a small IDLE/RUN/DONE controller.        |
// |               Borrow enables ripple combinationally between segments,    |
// |               so every accepted decrement lands in a single clock.       |
// | Ports       : CLK       - clock, all state updates on rising edge        |
// |               RST       - synchronous active-high reset                  |
// |               ENABLE    - decrement request                              |
// |               LOAD      - load DI (wins over ENABLE)                     |
// |               DI[W-1:0] - load value                                     |
// |               DO[W-1:0] - registered count                               |
// |               ZERO      - combinational, DO == 0                         |
// |               BUSY      - registered, state is RUN                       |
// |               UNDERFLOW - registered wrap pulse (wrap builds only)       |
// | Options     : define COUNTER_ROLLUNDER_WRAP_EN to let DONE wrap to       |
// |               all-ones on ENABLE; otherwise the count saturates at 0.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module counter_rollunder #(
  parameter int W = 256,
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ENABLE,
  input  logic         LOAD,
  input  logic [W-1:0] DI,
  output logic [W-1:0] DO,
  output logic         ZERO,
  output logic         BUSY
`ifdef COUNTER_ROLLUNDER_WRAP_EN
  ,
  output logic         UNDERFLOW
`endif
);

  localparam int SW = W / N;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_busy;
  logic [W-1:0] w_count;
  logic [N-1:0] w_tz;
  logic         w_dec;
  logic         w_count_is_one;

  // A decrement is only accepted while running and not overridden by LOAD.
  assign w_dec          = (r_state == S_RUN) && ENABLE && !LOAD;
  assign w_count_is_one = (w_count == {{(W-1){1'b0}}, 1'b1});

`ifdef COUNTER_ROLLUNDER_WRAP_EN
  logic r_underflow;
  logic w_wrap;
  // From DONE the count is zero, so "minus one" is simply all-ones everywhere.
  assign w_wrap = (r_state == S_DONE) && ENABLE && !LOAD;
`endif

  // Borrow enable chain: segment k steps only when every lower segment is 0,
  // i.e. when the lower part is about to wrap. Purely combinational so the
  // whole W-bit decrement resolves in one cycle.
  always_comb begin
    w_tz    = '0;
    w_tz[0] = 1'b1;
    for (int k = 1; k < N; k++) begin
      w_tz[k] = w_tz[k-1] && (w_count[(k-1)*SW +: SW] == '0);
    end
  end

  generate
    for (genvar k = 0; k < N; k++) begin : g_seg
      logic [SW-1:0] r_seg;

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_seg <= '0;
        end else if (LOAD) begin
          r_seg <= DI[k*SW +: SW];
`ifdef COUNTER_ROLLUNDER_WRAP_EN
        end else if (w_wrap) begin
          r_seg <= '1;
`endif
        end else if (w_dec && w_tz[k]) begin
          r_seg <= r_seg - 1'b1;
        end
      end

      assign w_count[k*SW +: SW] = r_seg;
    end
  endgenerate

  // Controller: state plus registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
`ifdef COUNTER_ROLLUNDER_WRAP_EN
      r_underflow <= 1'b0;
`endif
    end else begin
`ifdef COUNTER_ROLLUNDER_WRAP_EN
      r_underflow <= 1'b0;
`endif
      if (LOAD) begin
        if (DI != '0) begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
        end else begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
        end
      end else begin
        case (r_state)
          S_RUN: begin
            if (ENABLE && w_count_is_one) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end
          end
          S_DONE: begin
`ifdef COUNTER_ROLLUNDER_WRAP_EN
            if (ENABLE) begin
              r_state     <= S_RUN;
              r_busy      <= 1'b1;
              r_underflow <= 1'b1;
            end
`endif
          end
          default: begin
            // IDLE ignores ENABLE until the first LOAD.
          end
        endcase
      end
    end
  end

  assign DO   = w_count;
  assign ZERO = (w_count == '0);
  assign BUSY = r_busy;
`ifdef COUNTER_ROLLUNDER_WRAP_EN
  assign UNDERFLOW = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_rollunder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_counter_rollunder                                       |
// | Description : Scoreboard bench for counter_rollunder. Two instances      |
// |               (W=8/N=2 and W=256/N=4) share the control inputs. A driver |
// |               applies inputs on the falling edge and pushes the expected |
// |               post-edge outputs from an arithmetic model; a monitor pops |
// |               and compares just after every rising edge.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_counter_rollunder;

`ifdef COUNTER_ROLLUNDER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         load;
  logic         en;
  logic [7:0]   di_n;
  logic [7:0]   do_n;
  logic         zero_n;
  logic         busy_n;
  logic [255:0] di_w;
  logic [255:0] do_w;
  logic         zero_w;
  logic         busy_w;
`ifdef COUNTER_ROLLUNDER_WRAP_EN
  logic         uf_n;
  logic         uf_w;
`endif

  counter_rollunder #(.W(8), .N(2)) dut_narrow (
    .CLK    (clk),
    .RST    (rst),
    .ENABLE (en),
    .LOAD   (load),
    .DI     (di_n),
    .DO     (do_n),
    .ZERO   (zero_n),
    .BUSY   (busy_n)
`ifdef COUNTER_ROLLUNDER_WRAP_EN
    ,
    .UNDERFLOW (uf_n)
`endif
  );

  counter_rollunder #(.W(256), .N(4)) dut_wide (
    .CLK    (clk),
    .RST    (rst),
    .ENABLE (en),
    .LOAD   (load),
    .DI     (di_w),
    .DO     (do_w),
    .ZERO   (zero_w),
    .BUSY   (busy_w)
`ifdef COUNTER_ROLLUNDER_WRAP_EN
    ,
    .UNDERFLOW (uf_w)
`endif
  );

  // Reference model: a plain number plus "has been loaded since reset".
  typedef struct {
    logic [255:0] cnt;
    bit           armed;
    bit           uf;
  } mst_t;

  typedef struct {
    logic [7:0]   do_n;
    bit           zero_n;
    bit           busy_n;
    bit           uf_n;
    logic [255:0] do_w;
    bit           zero_w;
    bit           busy_w;
    bit           uf_w;
  } exp_t;

  mst_t sn;
  mst_t sw;
  exp_t q[$];
  int   n_checks;
  int   n_fail;

  function automatic mst_t model_next(mst_t s, bit r, bit l, bit e,
                                      logic [255:0] d, int width);
    logic [255:0] mask;
    mst_t         n;
    mask = (width == 256) ? {256{1'b1}} : ((256'd1 << width) - 256'd1);
    n    = s;
    n.uf = 1'b0;
    if (r) begin
      n.cnt   = '0;
      n.armed = 1'b0;
    end else if (l) begin
      n.cnt   = d & mask;
      n.armed = 1'b1;
    end else if (e && s.armed) begin
      if (s.cnt != '0) begin
        n.cnt = (s.cnt - 256'd1) & mask;
      end else if (WRAP) begin
        n.cnt = mask;
        n.uf  = 1'b1;
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit l, input bit e,
                       input logic [7:0] dn, input logic [255:0] dw);
    exp_t x;
    @(negedge clk);
    rst  = r;
    load = l;
    en   = e;
    di_n = dn;
    di_w = dw;
    sn = model_next(sn, r, l, e, {248'd0, dn}, 8);
    sw = model_next(sw, r, l, e, dw, 256);
    x.do_n   = sn.cnt[7:0];
    x.zero_n = (sn.cnt == '0);
    x.busy_n = sn.armed && (sn.cnt != '0);
    x.uf_n   = sn.uf;
    x.do_w   = sw.cnt;
    x.zero_w = (sw.cnt == '0);
    x.busy_w = sw.armed && (sw.cnt != '0);
    x.uf_w   = sw.uf;
    q.push_back(x);
  endtask

  function automatic logic [255:0] rand_wide();
    logic [255:0] v;
    int           k;
    v = '0;
    k = int'($urandom_range(1, 3));
    case ($urandom_range(0, 3))
      0: v = 256'($urandom_range(0, 3));
      1: v = 256'd1 << (64 * k);
      2: v = (256'd1 << (64 * k)) + 256'($urandom_range(0, 2));
      default: for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] rand_narrow();
    logic [7:0] v;
    case ($urandom_range(0, 2))
      0: v = 8'($urandom_range(0, 3));
      1: v = 8'h10 + 8'($urandom_range(0, 1));
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expectation per rising edge, compared just after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("do_n",   {248'd0, do_n},   {248'd0, e.do_n});
      check("zero_n", {255'd0, zero_n}, {255'd0, e.zero_n});
      check("busy_n", {255'd0, busy_n}, {255'd0, e.busy_n});
      check("do_w",   do_w,             e.do_w);
      check("zero_w", {255'd0, zero_w}, {255'd0, e.zero_w});
      check("busy_w", {255'd0, busy_w}, {255'd0, e.busy_w});
`ifdef COUNTER_ROLLUNDER_WRAP_EN
      check("uf_n",   {255'd0, uf_n},   {255'd0, e.uf_n});
      check("uf_w",   {255'd0, uf_w},   {255'd0, e.uf_w});
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b0;
    load = 1'b0;
    en   = 1'b0;
    di_n = '0;
    di_w = '0;
    sn.cnt = '0; sn.armed = 1'b0; sn.uf = 1'b0;
    sw.cnt = '0; sw.armed = 1'b0; sw.uf = 1'b0;

    // Reset, then ENABLE in IDLE must do nothing.
    repeat (2) drive(1, 0, 0, 8'h00, '0);
    repeat (5) drive(0, 0, 1, 8'h00, '0);

    // Borrow across segments: 0x10 -> 0x0F, 2^192 -> low three segments all-ones.
    drive(0, 1, 0, 8'h10, 256'd1 << 192);
    drive(0, 0, 1, 8'h00, '0);

    // Count down to zero, then one more ENABLE (saturate or wrap).
    drive(0, 1, 0, 8'h02, 256'd2);
    repeat (3) drive(0, 0, 1, 8'h00, '0);
    drive(0, 0, 0, 8'h00, '0);
    drive(0, 0, 1, 8'h00, '0);

    // LOAD beats ENABLE; LOAD 0 goes straight to DONE.
    drive(0, 1, 0, 8'h33, 256'h33);
    drive(0, 1, 1, 8'h80, 256'd1 << 255);
    drive(0, 1, 0, 8'h00, '0);
    repeat (2) drive(0, 0, 1, 8'h00, '0);

    // Reset mid-count beats LOAD and ENABLE; then IDLE until the next LOAD.
    drive(0, 1, 0, 8'h05, 256'd1 << 128);
    repeat (2) drive(0, 0, 1, 8'h00, '0);
    drive(1, 1, 1, 8'h77, 256'h77);
    repeat (3) drive(0, 0, 1, 8'h00, '0);

    // Random traffic with boundary-heavy load values.
    for (int i = 0; i < 600; i++) begin
      bit r;
      bit l;
      bit e;
      r = ($urandom_range(0, 99) < 2);
      l = ($urandom_range(0, 99) < 12);
      e = ($urandom_range(0, 99) < 75);
      drive(r, l, e, rand_narrow(), rand_wide());
    end

    // Let the last expectation be consumed, with a bounded wait.
    drive(0, 0, 0, 8'h00, '0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations required 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_rollunder.md
COUNTER_ROLLUNDER -- requirements
Module: counter_rollunder

Interface
REQ-001 Parameter W, default 256: total counter width in bits.
REQ-002 Parameter N, default 4: number of equal cascaded segments; W SHALL be an integer multiple of N.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 ENABLE  input  1  decrement request, sampled each cycle.
REQ-006 LOAD  input  1  load DI into the counter; has priority over ENABLE.
REQ-007 DI  input  W  load value; bit 0 is the LSB of segment 0.
REQ-008 DO  output  W  current count, registered; segment k occupies bits [W/N*(k+1)-1 : W/N*k].
REQ-009 ZERO  output  1  combinational, high when DO equals 0.
REQ-010 BUSY  output  1  registered, high while the state is RUN.
REQ-011 UNDERFLOW  output  1  registered one-cycle pulse on a wrap from 0 to all-ones; present only with the macro in REQ-027.

Function
REQ-012 The counter SHALL consist of N segments of width W/N, each a separate register.
REQ-013 Segment 0 borrow-enable tz[0] SHALL be 1; tz[k] SHALL be tz[k-1] AND (segment k-1 == 0) for k>0.
REQ-014 In an accepted decrement cycle, segment k SHALL decrement by 1 modulo 2^(W/N) if tz[k] is 1, and SHALL hold otherwise.
REQ-015 The aggregate result SHALL equal DO-1 modulo 2^W in the same cycle, with no pipelined borrow latency.
REQ-016 The FSM SHALL have three states: IDLE (reset, not loaded), RUN (count nonzero), DONE (count reached zero).
REQ-017 LOAD=1 in any state SHALL load DI into all segments on the next edge; next state is RUN if DI!=0, else DONE.
REQ-018 LOAD and ENABLE both high SHALL load DI only; no decrement, no UNDERFLOW.
REQ-019 In IDLE, ENABLE SHALL be ignored: DO, state and outputs hold.
REQ-020 In RUN with ENABLE=1 and LOAD=0, the counter SHALL decrement; if DO==1 before the edge, the next state is DONE.
REQ-021 In RUN with ENABLE=0, the counter and state SHALL hold.
REQ-022 In DONE, ENABLE behaviour SHALL be as specified in REQ-027/REQ-028.
REQ-023 The decrement latency from ENABLE sampled high to the updated DO SHALL be exactly one clock.

Reset
REQ-024 RST=1 SHALL force all segments to 0, state IDLE, BUSY=0 and UNDERFLOW=0 on the next edge; ZERO is therefore 1.
REQ-025 RST SHALL take priority over LOAD and ENABLE, including mid-count. After RST deasserts, the block SHALL stay in IDLE until LOAD.
REQ-026 No reset-less storage other than DI sampling; the block SHALL need no initial statements for correct behaviour.

Configuration
REQ-027 With COUNTER_ROLLUNDER_WRAP_EN defined: in DONE, ENABLE=1 and LOAD=0 SHALL set all segments to all-ones, pulse UNDERFLOW for one cycle, and move to RUN.
REQ-028 With COUNTER_ROLLUNDER_WRAP_EN undefined: the counter SHALL saturate at 0, ENABLE SHALL be ignored in DONE, and the UNDERFLOW port SHALL be absent.

Verification (W=8, N=2 unless stated)
REQ-029 RST for 2 cycles, then ENABLE=1 for 5 cycles -> DO=0x00, ZERO=1, BUSY=0 throughout.
REQ-030 LOAD DI=0x10, then ENABLE for 1 cycle -> DO=0x0F (borrow across segments); BUSY=1.
REQ-031 LOAD 0x02, then ENABLE for 3 cycles -> DO 0x01, 0x00, 0x00; BUSY falls when DO=0. Without the macro: no change on the 3rd cycle. With the macro: the 3rd cycle gives DO=0xFF with a 1-cycle UNDERFLOW pulse and BUSY=1.
REQ-032 LOAD=1 with DI=0x80 and ENABLE=1 together, from count 0x33 -> DO=0x80, no decrement. LOAD DI=0x00 -> state DONE, ZERO=1, BUSY=0.
REQ-033 W=256, N=4: LOAD 2^192, then ENABLE once -> segments 0..2 all-ones and segment 3=0. Assert RST during counting -> DO=0 and IDLE on the next edge.
